core_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core. Steps each instruction through

---
 rtl/core_pkg.sv | 43 ++++
 rtl/core_seq_ctrl_if.sv | 12 +
 rtl/core_next_pc.sv | 25 ++
 rtl/core_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: FSM states, trap
// causes, opcode constants and the legal-opcode check used in DECODE.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_ILLEGAL  = 2'b01,
    CAUSE_MISALIGN = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } trap_cause_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] MEMTOREG_LD = 2'b11;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_OP,
      OPC_OP_IMM, OPC_BRANCH, OPC_JAL, OPC_JALR: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Shared memory port between the sequencer (master) and memory (slave).
// Handshake: master raises mem_req with mem_we/mem_addr stable and holds them
// until mem_ack; mem_ack is a 1-cycle pulse, ignored while mem_req is low.
interface core_seq_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr, output mem_ack);
endinterface

// File: rtl/core_next_pc.sv
// Combinational next-PC selection for the WB stage plus the misalignment flag
// (bit 1 set means the target is not word aligned).
module core_next_pc (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch,
  input  logic        br_taken,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (jalr) begin
      next_pc = {alu_result[31:1], 1'b0};
    end else if (jal || (branch && br_taken)) begin
      next_pc = pc + imm;
    end
    misalign = next_pc[1];
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning the PC and the
// shared memory port; raises a sticky trap on illegal opcode, misalignment or timeout.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  core_seq_ctrl_if.master        mem,
  output logic                   ir_load,
  output logic                   mdr_load,
  input  logic [6:0]             dec_opcode,
  input  logic                   dec_regw,
  input  logic                   dec_memw,
  input  logic [1:0]             dec_memtoreg,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_branch,
  input  logic                   br_taken,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            imm,
  output logic                   rf_we,
  output logic [31:0]            pc,
  output logic                   retire,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output state_t                 state_dbg
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] pc_q;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc_q;
  logic        misalign_q;
  logic        trap_q;
  trap_cause_t cause_q;

  logic [31:0] next_pc_c;
  logic        misalign_c;

  logic        req_c, we_c, ir_load_c, mdr_load_c, rf_we_c, retire_c, trap_set_c;
  logic [31:0] addr_c;
  trap_cause_t cause_next_c;

  core_next_pc u_next_pc (
    .pc         (pc_q),
    .imm        (imm),
    .alu_result (alu_result),
    .jal        (dec_jal),
    .jalr       (dec_jalr),
    .branch     (dec_branch),
    .br_taken   (br_taken),
    .next_pc    (next_pc_c),
    .misalign   (misalign_c)
  );

  // Outputs are gated by rst so nothing is requested while reset is held.
  always_comb begin
    state_next   = state;
    req_c        = 1'b0;
    we_c         = 1'b0;
    addr_c       = pc_q;
    ir_load_c    = 1'b0;
    mdr_load_c   = 1'b0;
    rf_we_c      = 1'b0;
    retire_c     = 1'b0;
    trap_set_c   = 1'b0;
    cause_next_c = CAUSE_NONE;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          req_c  = 1'b1;
          addr_c = pc_q;
          if (mem.mem_ack) begin
            ir_load_c  = 1'b1;
            state_next = ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            trap_set_c   = 1'b1;
            cause_next_c = CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          if (is_legal_opcode(dec_opcode)) begin
            state_next = ST_EXECUTE;
          end else begin
            trap_set_c   = 1'b1;
            cause_next_c = CAUSE_ILLEGAL;
          end
        end
        ST_EXECUTE: begin
          if ((dec_memtoreg == MEMTOREG_LD) || dec_memw) state_next = ST_MEM;
          else                                             state_next = ST_WB;
        end
        ST_MEM: begin
          req_c  = 1'b1;
          we_c   = dec_memw;
          addr_c = alu_result;
          if (mem.mem_ack) begin
            mdr_load_c = (dec_memtoreg == MEMTOREG_LD);
            state_next = ST_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            trap_set_c   = 1'b1;
            cause_next_c = CAUSE_TIMEOUT;
          end
        end
        ST_WB: begin
          if (misalign_q) begin
            trap_set_c   = 1'b1;
            cause_next_c = CAUSE_MISALIGN;
          end else begin
            rf_we_c    = dec_regw;
            retire_c   = 1'b1;
            state_next = ST_FETCH;
          end
        end
        ST_TRAP: begin
          state_next = ST_TRAP;
        end
        default: begin
          state_next = ST_TRAP;
        end
      endcase
      if (trap_set_c) state_next = ST_TRAP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      pc_q       <= RESET_PC;
      wait_cnt   <= 8'd0;
      next_pc_q  <= RESET_PC;
      misalign_q <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state <= state_next;
      // FETCH and MEM are never adjacent, so clearing on any ack or idle cycle
      // restarts the count on every entry into a memory state.
      if (req_c && !mem.mem_ack) wait_cnt <= wait_cnt + 8'd1;
      else                       wait_cnt <= 8'd0;
      if (state == ST_EXECUTE) begin
        next_pc_q  <= next_pc_c;
        misalign_q <= misalign_c;
      end
      if (retire_c) pc_q <= next_pc_q;
      if (trap_set_c) begin
        trap_q  <= 1'b1;
        cause_q <= cause_next_c;
      end
    end
  end

  assign mem.mem_req  = req_c;
  assign mem.mem_we   = we_c;
  assign mem.mem_addr = addr_c;
  assign ir_load      = ir_load_c;
  assign mdr_load     = mdr_load_c;
  assign rf_we        = rf_we_c;
  assign retire       = retire_c;
  assign pc           = pc_q;
  assign trap         = trap_q;
  assign trap_cause   = cause_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: runs single instructions with scripted
// memory wait states and checks strobes, timing, PC and trap behaviour.
module tb_core_seq_ctrl;
  import core_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_seq_ctrl_if mem ();

  logic        ir_load, mdr_load, rf_we, retire, trap;
  logic [6:0]  dec_opcode;
  logic        dec_regw, dec_memw, dec_jal, dec_jalr, dec_branch, br_taken;
  logic [1:0]  dec_memtoreg, trap_cause;
  logic [31:0] alu_result, imm, pc;
  state_t      state_dbg;

  core_seq_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mem),
    .ir_load      (ir_load),
    .mdr_load     (mdr_load),
    .dec_opcode   (dec_opcode),
    .dec_regw     (dec_regw),
    .dec_memw     (dec_memw),
    .dec_memtoreg (dec_memtoreg),
    .dec_jal      (dec_jal),
    .dec_jalr     (dec_jalr),
    .dec_branch   (dec_branch),
    .br_taken     (br_taken),
    .alu_result   (alu_result),
    .imm          (imm),
    .rf_we        (rf_we),
    .pc           (pc),
    .retire       (retire),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state_dbg    (state_dbg)
  );

  // scoreboard: expected memory addresses in acceptance order
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int cyc, n_req, n_we, we_cyc, n_ir, n_mdr, mdr_cyc, n_rf, rf_cyc, n_ret;
  bit done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Drives one instruction; fw/mw are the ack delays (in request cycles) for
  // the fetch and the data access. Stops after retire, trap or the cycle limit.
  task automatic run_instr(input logic [6:0] op, input logic regw, input logic memw,
                           input logic [1:0] mtr, input logic jal, input logic jalr,
                           input logic br, input logic taken, input logic [31:0] alu,
                           input logic [31:0] immv, input int fw, input int mw,
                           input int limit);
    int  age, idx;
    bit  acked;
    dec_opcode = op;   dec_regw = regw; dec_memw = memw; dec_memtoreg = mtr;
    dec_jal = jal;     dec_jalr = jalr; dec_branch = br;  br_taken = taken;
    alu_result = alu;  imm = immv;
    cyc = 0; n_req = 0; n_we = 0; we_cyc = -1; n_ir = 0; n_mdr = 0; mdr_cyc = -1;
    n_rf = 0; rf_cyc = -1; n_ret = 0; done = 0; age = 0; idx = 0;
    while (!done && cyc < limit) begin
      acked = mem.mem_req && (age == ((idx == 0) ? fw : mw));
      mem.mem_ack = acked;
      #1;
      if (mem.mem_req) n_req++;
      if (mem.mem_we)  begin n_we++;  we_cyc  = cyc; end
      if (ir_load)     n_ir++;
      if (mdr_load)    begin n_mdr++; mdr_cyc = cyc; end
      if (rf_we)       begin n_rf++;  rf_cyc  = cyc; end
      if (retire)      n_ret++;
      if (acked) begin
        if (exp_q.size() > 0) check("mem_addr", mem.mem_addr, exp_q.pop_front());
        idx++;
        age = 0;
      end else if (mem.mem_req) begin
        age++;
      end
      @(posedge clk);
      #1;
      mem.mem_ack = 1'b0;
      cyc++;
      if (n_ret > 0 || trap) done = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem.mem_ack = 1'b0;
    dec_opcode = 7'h13; dec_regw = 0; dec_memw = 0; dec_memtoreg = 2'b00;
    dec_jal = 0; dec_jalr = 0; dec_branch = 0; br_taken = 0;
    alu_result = 32'h0; imm = 32'h0;

    // reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_cause", {30'b0, trap_cause}, 32'd0);
    check("rst_mem_req", {31'b0, mem.mem_req}, 32'd0);
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_state", {29'b0, state_dbg}, {29'b0, ST_FETCH});
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ADDI at 0, zero-wait fetch
    exp_q.push_back(32'h0);
    run_instr(7'h13, 1, 0, 2'b00, 0, 0, 0, 0, 32'h5, 32'h5, 0, 0, 50);
    check("addi_done", {31'b0, done}, 32'd1);
    check("addi_nreq", n_req, 1);
    check("addi_nir", n_ir, 1);
    check("addi_rf_cyc", rf_cyc, 3);
    check("addi_nrf", n_rf, 1);
    check("addi_nret", n_ret, 1);
    check("addi_pc", pc, 32'h4);

    // LW, data ack three cycles late
    exp_q.push_back(32'h4); exp_q.push_back(32'h100);
    run_instr(7'h03, 1, 0, 2'b11, 0, 0, 0, 0, 32'h100, 32'h100, 0, 3, 50);
    check("lw_mdr_cyc", mdr_cyc, 6);
    check("lw_rf_cyc", rf_cyc, 7);
    check("lw_nmdr", n_mdr, 1);
    check("lw_nreq", n_req, 5);
    check("lw_nwe", n_we, 0);
    check("lw_pc", pc, 32'h8);

    // SW, one-cycle fetch wait
    exp_q.push_back(32'h8); exp_q.push_back(32'h200);
    run_instr(7'h23, 0, 1, 2'b00, 0, 0, 0, 0, 32'h200, 32'h200, 1, 0, 50);
    check("sw_nwe", n_we, 1);
    check("sw_we_cyc", we_cyc, 4);
    check("sw_nrf", n_rf, 0);
    check("sw_nret", n_ret, 1);
    check("sw_pc", pc, 32'hC);

    // ack on the last allowed cycle beats the timeout
    exp_q.push_back(32'hC);
    run_instr(7'h13, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 254, 0, 400);
    check("late_ack_trap", {31'b0, trap}, 32'd0);
    check("late_ack_nreq", n_req, 255);
    check("late_ack_pc", pc, 32'h10);

    // BEQ taken, imm = -8, at 0x10
    exp_q.push_back(32'h10);
    run_instr(7'h63, 0, 0, 2'b00, 0, 0, 1, 1, 32'h0, 32'hFFFF_FFF8, 0, 0, 50);
    check("beq_t_pc", pc, 32'h8);
    check("beq_t_nrf", n_rf, 0);

    // JAL imm = 8 at 0x08
    exp_q.push_back(32'h8);
    run_instr(7'h6F, 1, 0, 2'b00, 1, 0, 0, 0, 32'hC, 32'h8, 0, 0, 50);
    check("jal_pc", pc, 32'h10);
    check("jal_nrf", n_rf, 1);

    // BEQ not taken at 0x10
    exp_q.push_back(32'h10);
    run_instr(7'h63, 0, 0, 2'b00, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFF8, 0, 0, 50);
    check("beq_nt_pc", pc, 32'h14);

    // JALR target bit 0 cleared
    exp_q.push_back(32'h14);
    run_instr(7'h67, 1, 0, 2'b00, 0, 1, 0, 0, 32'h101, 32'h0, 0, 0, 50);
    check("jalr_pc", pc, 32'h100);

    // JALR to 0x102 is misaligned
    exp_q.push_back(32'h100);
    run_instr(7'h67, 1, 0, 2'b00, 0, 1, 0, 0, 32'h103, 32'h0, 0, 0, 50);
    check("jalr_mis_trap", {31'b0, trap}, 32'd1);
    check("jalr_mis_cause", {30'b0, trap_cause}, 32'd2);
    check("jalr_mis_pc", pc, 32'h100);
    check("jalr_mis_nrf", n_rf, 0);
    check("jalr_mis_nret", n_ret, 0);

    // trap holds; stray ack ignored
    repeat (3) @(posedge clk);
    #1;
    mem.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem.mem_ack = 1'b0;
    check("trap_hold_state", {29'b0, state_dbg}, {29'b0, ST_TRAP});
    check("trap_hold_req", {31'b0, mem.mem_req}, 32'd0);
    check("trap_hold_pc", pc, 32'h100);

    // JAL imm = 2 at 0 -> misaligned
    do_reset();
    check("rst2_pc", pc, 32'h0);
    exp_q.push_back(32'h0);
    run_instr(7'h6F, 1, 0, 2'b00, 1, 0, 0, 0, 32'h4, 32'h2, 0, 0, 50);
    check("jal2_trap", {31'b0, trap}, 32'd1);
    check("jal2_cause", {30'b0, trap_cause}, 32'd2);
    check("jal2_pc", pc, 32'h0);

    // illegal opcode
    do_reset();
    exp_q.push_back(32'h0);
    run_instr(7'h7F, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 50);
    check("ill_trap", {31'b0, trap}, 32'd1);
    check("ill_cause", {30'b0, trap_cause}, 32'd1);
    check("ill_nret", n_ret, 0);
    check("ill_cyc", cyc, 2);

    // fetch never acknowledged
    do_reset();
    run_instr(7'h13, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 1000, 0, 400);
    check("to_done", {31'b0, done}, 32'd1);
    check("to_cause", {30'b0, trap_cause}, 32'd3);
    check("to_nreq", n_req, 255);
    check("to_nir", n_ir, 0);

    // reset in the middle of MEM
    do_reset();
    exp_q.push_back(32'h0);
    run_instr(7'h13, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 50);
    check("mid_pre_pc", pc, 32'h4);
    exp_q.push_back(32'h4);
    run_instr(7'h03, 1, 0, 2'b11, 0, 0, 0, 0, 32'h300, 32'h0, 0, 1000, 6);
    check("mid_not_done", {31'b0, done}, 32'd0);
    check("mid_state_mem", {29'b0, state_dbg}, {29'b0, ST_MEM});
    check("mid_mem_addr", mem.mem_addr, 32'h300);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_state", {29'b0, state_dbg}, {29'b0, ST_FETCH});
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_req", {31'b0, mem.mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_post_req", {31'b0, mem.mem_req}, 32'd1);
    check("mid_post_addr", mem.mem_addr, 32'h0);
    check("exp_q_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
